// File: rtl/e203_nice_csr_bank.sv
// NICE-side CSR bank (NCTRL/NSTAT/NCYCLE/NSCRATCH) with a write-latency stall after accepted writes.
// Define E203_NICE_CSR_CYCLE_EN to implement the free-running NCYCLE counter at index 0x02.
module e203_nice_csr_bank #(
    parameter int unsigned WR_LAT   = 2,
    parameter logic [31:0] CTRL_RST = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nice_csr_valid,
    output logic        nice_csr_ready,
    input  logic [31:0] nice_csr_addr,
    input  logic        nice_csr_wr,
    input  logic [31:0] nice_csr_wdata,
    output logic [31:0] nice_csr_rdata,
    output logic        nice_ctrl_en,
    output logic [3:0]  nice_ctrl_mode
);
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [3:0] LAT_LOAD = (WR_LAT == 0) ? 4'd0 : 4'(WR_LAT - 1);

    state_t      r_state;
    logic [3:0]  r_lat_cnt;
    logic        r_ctrl_en;
    logic [3:0]  r_ctrl_mode;
    logic [15:0] r_wr_cnt;
    logic [15:0] r_unmap_cnt;
    logic [31:0] r_scratch;
    logic [31:0] w_ncycle;

    logic        w_ready;
    logic        w_acc;
    logic        w_wr_acc;
    logic        w_mapped;
    logic [7:0]  w_idx;
    logic        w_unused_addr;

    // Upper index bits are already qualified upstream; only [7:0] selects a register.
    assign w_idx         = nice_csr_addr[7:0];
    assign w_unused_addr = ^nice_csr_addr[31:8];
    assign w_ready       = (r_state == S_IDLE);
    assign w_acc         = nice_csr_valid & w_ready;
    assign w_wr_acc      = w_acc & nice_csr_wr;
    assign w_mapped      = (w_idx[7:2] == 6'd0);

    assign nice_csr_ready = w_ready;
    assign nice_ctrl_en   = r_ctrl_en;
    assign nice_ctrl_mode = r_ctrl_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lat_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_acc && (WR_LAT != 0)) begin
                        r_state   <= S_BUSY;
                        r_lat_cnt <= LAT_LOAD;
                    end
                end
                S_BUSY: begin
                    if (r_lat_cnt == 4'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl_en   <= CTRL_RST[0];
            r_ctrl_mode <= CTRL_RST[7:4];
            r_wr_cnt    <= 16'd0;
            r_unmap_cnt <= 16'd0;
            r_scratch   <= 32'd0;
        end else begin
            if (w_wr_acc && (w_idx == 8'h00)) begin
                r_ctrl_en   <= nice_csr_wdata[0];
                r_ctrl_mode <= nice_csr_wdata[7:4];
            end
            if (w_wr_acc && (w_idx == 8'h03)) begin
                r_scratch <= nice_csr_wdata;
            end
            // Writes to NSTAT itself still count as accepted writes.
            if (w_wr_acc && (r_wr_cnt != 16'hFFFF)) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
            if (w_acc && !w_mapped && (r_unmap_cnt != 16'hFFFF)) begin
                r_unmap_cnt <= r_unmap_cnt + 16'd1;
            end
        end
    end

`ifdef E203_NICE_CSR_CYCLE_EN
    logic [31:0] r_ncycle;

    // An explicit write takes priority over the running increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ncycle <= 32'd0;
        end else if (w_wr_acc && (w_idx == 8'h02)) begin
            r_ncycle <= nice_csr_wdata;
        end else if (r_ctrl_en) begin
            r_ncycle <= r_ncycle + 32'd1;
        end
    end

    assign w_ncycle = r_ncycle;
`else
    assign w_ncycle = 32'd0;
`endif

    always_comb begin
        nice_csr_rdata = 32'd0;
        case (w_idx)
            8'h00:   nice_csr_rdata = {24'd0, r_ctrl_mode, 3'd0, r_ctrl_en};
            8'h01:   nice_csr_rdata = {r_unmap_cnt, r_wr_cnt};
            8'h02:   nice_csr_rdata = w_ncycle;
            8'h03:   nice_csr_rdata = r_scratch;
            default: nice_csr_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_e203_nice_csr_bank.sv
// Directed bench for e203_nice_csr_bank: one WR_LAT=2 instance and one WR_LAT=0 instance.
// NCYCLE expectations follow E203_NICE_CSR_CYCLE_EN.
module tb_e203_nice_csr_bank;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        valid = 1'b0, wr = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        ready, en;
    logic [31:0] rdata;
    logic [3:0]  mode;

    logic        v0 = 1'b0, w0 = 1'b0;
    logic [31:0] a0 = 32'h0, d0 = 32'h0;
    logic        ready0, en0;
    logic [31:0] rdata0;
    logic [3:0]  mode0;

    int errors = 0;
    int checks = 0;

`ifdef E203_NICE_CSR_CYCLE_EN
    localparam logic [31:0] EXP_CYC5 = 32'd5;
`else
    localparam logic [31:0] EXP_CYC5 = 32'd0;
`endif

    always #5 clk = ~clk;

    e203_nice_csr_bank #(.WR_LAT(2), .CTRL_RST(32'h0)) u_dut (
        .clk(clk), .rst(rst),
        .nice_csr_valid(valid), .nice_csr_ready(ready),
        .nice_csr_addr(addr), .nice_csr_wr(wr),
        .nice_csr_wdata(wdata), .nice_csr_rdata(rdata),
        .nice_ctrl_en(en), .nice_ctrl_mode(mode)
    );

    e203_nice_csr_bank #(.WR_LAT(0), .CTRL_RST(32'h0)) u_dut0 (
        .clk(clk), .rst(rst),
        .nice_csr_valid(v0), .nice_csr_ready(ready0),
        .nice_csr_addr(a0), .nice_csr_wr(w0),
        .nice_csr_wdata(d0), .nice_csr_rdata(rdata0),
        .nice_ctrl_en(en0), .nice_ctrl_mode(mode0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        valid = 1'b1; wr = 1'b0; addr = a;
        #1;
        check(tag, rdata, exp);
        $display("read  addr=%h rdata=%h exp=%h", a, rdata, exp);
        tick();
        valid = 1'b0;
    endtask

    task automatic wrt(input logic [31:0] a, input logic [31:0] d);
        valid = 1'b1; wr = 1'b1; addr = a; wdata = d;
        $display("write addr=%h wdata=%h", a, d);
        tick();
        valid = 1'b0; wr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_en", {31'd0, en}, 32'd0);
        check("rst_mode", {28'd0, mode}, 32'd0);
        rd(32'hE00, 32'h0, "rst_nctrl");
        rd(32'hE01, 32'h0, "rst_nstat");
        rd(32'hE02, 32'h0, "rst_ncycle");
        rd(32'hE03, 32'h0, "rst_nscratch");

        // Write latency stall of exactly 2 cycles
        wrt(32'hE03, 32'hDEADBEEF);
        check("stall_c1", {31'd0, ready}, 32'd0);
        tick();
        check("stall_c2", {31'd0, ready}, 32'd0);
        tick();
        check("stall_end", {31'd0, ready}, 32'd1);
        rd(32'hE03, 32'hDEADBEEF, "scratch_rb");
        rd(32'hE01, 32'h0000_0001, "nstat_1wr");

        // NCTRL masking, control outputs, NCYCLE counting from the new enable
        wrt(32'hE00, 32'hFFFF_FFFF);
        check("ctrl_en", {31'd0, en}, 32'd1);
        check("ctrl_mode", {28'd0, mode}, 32'hF);
        tick(); tick();
        check("ctrl_ready", {31'd0, ready}, 32'd1);
        tick(); tick(); tick();
        rd(32'hE02, EXP_CYC5, "ncycle_5");
        rd(32'hE00, 32'h0000_00F1, "nctrl_rb");

        // NCYCLE write wins over increment, then wraps
        wrt(32'hE02, 32'hFFFF_FFFE);
        tick(); tick();
        check("wrap_ready", {31'd0, ready}, 32'd1);
        rd(32'hE02, 32'h0, "ncycle_wrap");
        rd(32'hE01, 32'h0000_0003, "nstat_3wr");

        // Unmapped accesses
        rd(32'hE40, 32'h0, "unmap_rd");
        valid = 1'b1; wr = 1'b1; addr = 32'hE41; wdata = 32'h1234;
        #1;
        check("unmap_wr_rdata", rdata, 32'h0);
        $display("write addr=%h wdata=%h", addr, wdata);
        tick();
        valid = 1'b0; wr = 1'b0;
        tick(); tick();
        rd(32'hE01, 32'h0002_0004, "nstat_unmap");

        // NSTAT write ignored for data but counted
        wrt(32'hE01, 32'hFFFF_FFFF);
        tick(); tick();
        rd(32'hE01, 32'h0002_0005, "nstat_selfwr");

        // Reset during BUSY
        wrt(32'hE03, 32'h5);
        tick(); tick();
        rd(32'hE03, 32'h5, "scratch_5");
        wrt(32'hE03, 32'h7);
        check("busy_before_rst", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy_ready", {31'd0, ready}, 32'd1);
        check("rst_busy_en", {31'd0, en}, 32'd0);
        rd(32'hE03, 32'h0, "rst_busy_scratch");
        rd(32'hE01, 32'h0, "rst_busy_nstat");
        rd(32'hE00, 32'h0, "rst_busy_nctrl");

        // WR_LAT=0: back-to-back writes with ready held high
        v0 = 1'b1; w0 = 1'b1; a0 = 32'hE03; d0 = 32'hAA;
        #1;
        check("b2b_ready0", {31'd0, ready0}, 32'd1);
        $display("write0 addr=%h wdata=%h", a0, d0);
        tick();
        d0 = 32'hBB;
        check("b2b_ready1", {31'd0, ready0}, 32'd1);
        $display("write0 addr=%h wdata=%h", a0, d0);
        tick();
        a0 = 32'hE41; d0 = 32'hCC;
        check("b2b_ready2", {31'd0, ready0}, 32'd1);
        $display("write0 addr=%h wdata=%h", a0, d0);
        tick();
        v0 = 1'b0; w0 = 1'b0;
        check("b2b_ready3", {31'd0, ready0}, 32'd1);
        a0 = 32'hE03;
        #1;
        check("b2b_scratch", rdata0, 32'hBB);
        $display("read0 addr=%h rdata=%h", a0, rdata0);
        a0 = 32'hE01;
        #1;
        check("b2b_nstat", rdata0, 32'h0001_0003);
        $display("read0 addr=%h rdata=%h", a0, rdata0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
